banco_registro_multi: RTL and testbench

Parametrised register bank, successor to the team's basic two-read/one-write bank. Adds asynchronous reset of the whole array and optional registered reads with write-first bypass. Adds an optional hard-wired zero register and a hardware clear sequencer that sweeps a fill value into every register. It sits between the datapath control FSM and the ALU/display path.

---
 rtl/banco_if.sv | 31 +++
 rtl/banco_registro_multi.sv | 133 +++++++++++++
 tb/tb_banco_registro_multi.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banco_if.sv
// Bus bundle for the multi-port register bank: two read ports, one write port
// and the clear-sweep control/status signals.
interface banco_if #(
  parameter int BIT_ADDR = 3,
  parameter int BIT_DATO = 4
);
  logic [BIT_ADDR-1:0] addrRa;
  logic [BIT_ADDR-1:0] addrRb;
  logic [BIT_DATO-1:0] datOutRa;
  logic [BIT_DATO-1:0] datOutRb;
  logic [BIT_ADDR-1:0] addrW;
  logic [BIT_DATO-1:0] datW;
  logic                RegWrite;
  logic                clrStart;
  logic [BIT_DATO-1:0] clrVal;
  logic                busy;
  logic                clrDone;
  logic                wrErr;

  // Datapath control side: issues addresses, writes and sweep requests.
  modport master (
    output addrRa, addrRb, addrW, datW, RegWrite, clrStart, clrVal,
    input  datOutRa, datOutRb, busy, clrDone, wrErr
  );

  // Register bank side.
  modport slave (
    input  addrRa, addrRb, addrW, datW, RegWrite, clrStart, clrVal,
    output datOutRa, datOutRb, busy, clrDone, wrErr
  );
endinterface

// File: rtl/banco_registro_multi.sv
// Parametrised 2-read/1-write register bank with async reset, optional
// registered reads, write bypass, hard-wired zero register and clear sweeper.
module banco_registro_multi #(
  parameter int BIT_ADDR = 3,
  parameter int BIT_DATO = 4,
  parameter int READ_REG = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input logic   clk,
  input logic   rst,
  banco_if.slave bus
);
  localparam int NREG = 2 ** BIT_ADDR;
  localparam logic [BIT_ADDR-1:0] LAST_ADDR = BIT_ADDR'(NREG - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t              state;
  state_t              stateNext;
  logic [BIT_DATO-1:0] breg [NREG];
  logic [BIT_ADDR-1:0] ptr;
  logic [BIT_DATO-1:0] fill;
  logic                errQ;

  logic                startSweep;
  logic                wrAccept;
  logic                sweepWr;
  logic                fwdA;
  logic                fwdB;
  logic [BIT_DATO-1:0] nextA;
  logic [BIT_DATO-1:0] nextB;

  // Port writes are locked out only while sweeping; DONE accepts them.
  assign startSweep = (state == IDLE) && bus.clrStart;
  assign wrAccept   = bus.RegWrite && (state != SWEEP) &&
                      !((ZERO_REG != 0) && (bus.addrW == '0));
  assign sweepWr    = (state == SWEEP) && !((ZERO_REG != 0) && (ptr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    // NOTE: assign every always_comb output a default first so no path through the case leaves it unassigned and infers a latch.
    stateNext = state;
    case (state)
      IDLE:    if (bus.clrStart) stateNext = SWEEP;
      SWEEP:   if (ptr == LAST_ADDR) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Sweep pointer and fill value are captured together on the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values regardless of block order.
      ptr  <= '0;
      fill <= '0;
    end else if (startSweep) begin
      ptr  <= '0;
      fill <= bus.clrVal;
    end else if (state == SWEEP) begin
      ptr  <= ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the whole array is cleared by async reset, so it must map to flops rather than a RAM macro.
      for (int i = 0; i < NREG; i++) breg[i] <= '0;
    end else if (sweepWr) begin
      breg[ptr] <= fill;
    end else if (wrAccept) begin
      breg[bus.addrW] <= bus.datW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) errQ <= 1'b0;
    else     errQ <= (state == SWEEP) && bus.RegWrite;
  end

  // Zero register wins over bypass; bypass only ever carries port writes.
  function automatic logic [BIT_DATO-1:0] readPort(
    input logic [BIT_ADDR-1:0] addr,
    input logic [BIT_DATO-1:0] stored,
    input logic                fwd,
    input logic [BIT_DATO-1:0] wdata
  );
    logic [BIT_DATO-1:0] val;
    val = stored;
    if ((BYPASS != 0) && fwd) val = wdata;
    if ((ZERO_REG != 0) && (addr == '0)) val = '0;
    return val;
  endfunction

  assign fwdA  = wrAccept && (bus.addrRa == bus.addrW);
  assign fwdB  = wrAccept && (bus.addrRb == bus.addrW);
  assign nextA = readPort(bus.addrRa, breg[bus.addrRa], fwdA, bus.datW);
  assign nextB = readPort(bus.addrRb, breg[bus.addrRb], fwdB, bus.datW);

  generate
    if (READ_REG != 0) begin : gen_rd_reg
      logic [BIT_DATO-1:0] rdA;
      logic [BIT_DATO-1:0] rdB;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdA <= '0;
          rdB <= '0;
        end else begin
          rdA <= nextA;
          rdB <= nextB;
        end
      end
      assign bus.datOutRa = rdA;
      assign bus.datOutRb = rdB;
    end else begin : gen_rd_comb
      assign bus.datOutRa = nextA;
      assign bus.datOutRb = nextB;
    end
  endgenerate

  assign bus.busy    = (state == SWEEP);
  assign bus.clrDone = (state == DONE);
  assign bus.wrErr   = errQ;
endmodule

// File: tb/tb_banco_registro_multi.sv
// Bench for banco_registro_multi: four configurations driven in lockstep and
// compared against an array-based model, plus vector table and corner sequences.
module tb_banco_registro_multi;
  localparam int NDUT = 4;
  localparam int NREG = 8;

  // Configurations: 0 defaults, 1 registered+bypass, 2 registered no bypass, 3 zero reg.
  function automatic bit cfgRR(input int c); return (c == 1) || (c == 2); endfunction
  function automatic bit cfgBY(input int c); return c != 2; endfunction
  function automatic bit cfgZR(input int c); return c == 3; endfunction

  logic       clk;
  logic       rst;
  logic [2:0] addrRa, addrRb, addrW;
  logic [3:0] datW, clrVal;
  logic       RegWrite, clrStart;

  logic [3:0] outA [NDUT];
  logic [3:0] outB [NDUT];
  logic       outBusy [NDUT];
  logic       outDone [NDUT];
  logic       outErr  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    localparam int RR = (g == 1 || g == 2) ? 1 : 0;
    localparam int BY = (g == 2) ? 0 : 1;
    localparam int ZR = (g == 3) ? 1 : 0;
    banco_if #(.BIT_ADDR(3), .BIT_DATO(4)) bus ();
    assign bus.addrRa   = addrRa;
    assign bus.addrRb   = addrRb;
    assign bus.addrW    = addrW;
    assign bus.datW     = datW;
    assign bus.RegWrite = RegWrite;
    assign bus.clrStart = clrStart;
    assign bus.clrVal   = clrVal;
    banco_registro_multi #(
      .BIT_ADDR(3), .BIT_DATO(4), .READ_REG(RR), .BYPASS(BY), .ZERO_REG(ZR)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign outA[g]    = bus.datOutRa;
    assign outB[g]    = bus.datOutRb;
    assign outBusy[g] = bus.busy;
    assign outDone[g] = bus.clrDone;
    assign outErr[g]  = bus.wrErr;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: plain arrays plus "sweep cycles remaining" counter.
  int mem [NDUT][NREG];
  int sweepLeft [NDUT];
  int fillV [NDUT];
  int rdA [NDUT];
  int rdB [NDUT];
  bit doneF [NDUT];
  bit errF [NDUT];

  function automatic bit writeOk(input int c);
    return RegWrite && (sweepLeft[c] == 0) && !(cfgZR(c) && addrW == 3'd0);
  endfunction

  function automatic int modelRead(input int c, input int a);
    if (cfgZR(c) && a == 0) return 0;
    if (cfgBY(c) && writeOk(c) && a == int'(addrW)) return int'(datW);
    return mem[c][a];
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NDUT; c++) begin
      for (int i = 0; i < NREG; i++) mem[c][i] = 0;
      sweepLeft[c] = 0; fillV[c] = 0; rdA[c] = 0; rdB[c] = 0;
      doneF[c] = 1'b0; errF[c] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    for (int c = 0; c < NDUT; c++) begin
      int nA, nB, pos;
      bit w;
      nA = modelRead(c, int'(addrRa));
      nB = modelRead(c, int'(addrRb));
      w  = writeOk(c);
      if (sweepLeft[c] > 0) begin
        pos = NREG - sweepLeft[c];
        if (!(cfgZR(c) && pos == 0)) mem[c][pos] = fillV[c];
        errF[c] = RegWrite;
        sweepLeft[c]--;
        doneF[c] = (sweepLeft[c] == 0);
      end else begin
        if (w) mem[c][int'(addrW)] = int'(datW);
        errF[c] = 1'b0;
        if (clrStart && !doneF[c]) begin
          sweepLeft[c] = NREG;
          fillV[c] = int'(clrVal);
        end
        doneF[c] = 1'b0;
      end
      rdA[c] = nA;
      rdB[c] = nB;
    end
  endtask

  task automatic checkModel();
    for (int c = 0; c < NDUT; c++) begin
      int ea, eb;
      ea = cfgRR(c) ? rdA[c] : modelRead(c, int'(addrRa));
      eb = cfgRR(c) ? rdB[c] : modelRead(c, int'(addrRb));
      check($sformatf("dut%0d datOutRa", c), int'(outA[c]), ea);
      check($sformatf("dut%0d datOutRb", c), int'(outB[c]), eb);
      check($sformatf("dut%0d busy", c), int'(outBusy[c]), (sweepLeft[c] > 0) ? 1 : 0);
      check($sformatf("dut%0d clrDone", c), int'(outDone[c]), int'(doneF[c]));
      check($sformatf("dut%0d wrErr", c), int'(outErr[c]), int'(errF[c]));
    end
  endtask

  typedef struct {
    logic [2:0] ra, rb, aw;
    logic [3:0] dw;
    logic       we;
    logic [3:0] expA, expB;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input logic [2:0] ra, input logic [2:0] rb, input logic we,
                       input logic [2:0] aw, input logic [3:0] dw,
                       input logic cs, input logic [3:0] cv);
    addrRa = ra; addrRb = rb; RegWrite = we; addrW = aw; datW = dw;
    clrStart = cs; clrVal = cv;
  endtask

  // Inputs change at negedge; outputs sampled 1 unit before the rising edge.
  task automatic settle(); #4; endtask
  task automatic advance();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask
  task automatic tick(); settle(); checkModel(); advance(); endtask

  task automatic applyReset();
    drive(3'd0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b0, 4'd0);
    rst = 1'b1;
    modelReset();
    #2;
    checkModel();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int busyCnt, doneCnt, errCnt;

  initial begin
    rst = 1'b1;
    // Reset reads (DUT0 view) then the basic write/read/bypass pattern.
    for (int a = 0; a < NREG; a++)
      tbl.push_back('{ra: 3'(a), rb: 3'(7 - a), aw: 3'd0, dw: 4'd0, we: 1'b0, expA: 4'd0, expB: 4'd0});
    tbl.push_back('{ra: 3'd5, rb: 3'd2, aw: 3'd5, dw: 4'hA, we: 1'b1, expA: 4'hA, expB: 4'h0});
    tbl.push_back('{ra: 3'd5, rb: 3'd2, aw: 3'd2, dw: 4'h3, we: 1'b1, expA: 4'hA, expB: 4'h3});
    tbl.push_back('{ra: 3'd5, rb: 3'd2, aw: 3'd0, dw: 4'h0, we: 1'b0, expA: 4'hA, expB: 4'h3});
    tbl.push_back('{ra: 3'd6, rb: 3'd5, aw: 3'd6, dw: 4'hF, we: 1'b1, expA: 4'hF, expB: 4'hA});
    tbl.push_back('{ra: 3'd6, rb: 3'd0, aw: 3'd0, dw: 4'h0, we: 1'b0, expA: 4'hF, expB: 4'h0});

    applyReset();
    foreach (tbl[i]) begin
      drive(tbl[i].ra, tbl[i].rb, tbl[i].we, tbl[i].aw, tbl[i].dw, 1'b0, 4'd0);
      settle();
      check($sformatf("vec%0d datOutRa", i), int'(outA[0]), int'(tbl[i].expA));
      check($sformatf("vec%0d datOutRb", i), int'(outB[0]), int'(tbl[i].expB));
      checkModel();
      advance();
    end

    // Registered reads: write-first vs old-value behaviour.
    drive(3'd4, 3'd4, 1'b1, 3'd4, 4'h7, 1'b0, 4'd0);
    tick();
    drive(3'd4, 3'd4, 1'b0, 3'd0, 4'd0, 1'b0, 4'd0);
    settle();
    check("rdreg bypass new value", int'(outA[1]), 7);
    check("rdreg nobypass old value", int'(outA[2]), 0);
    checkModel();
    advance();
    settle();
    check("rdreg nobypass later value", int'(outA[2]), 7);
    checkModel();
    advance();

    // Clear sweep with 0x9, a repeated clrStart and a rejected write inside it.
    drive(3'd1, 3'd0, 1'b0, 3'd0, 4'd0, 1'b1, 4'h9);
    tick();
    busyCnt = 0; doneCnt = 0; errCnt = 0;
    for (int i = 0; i < 14; i++) begin
      drive(3'd1, 3'(i), (i == 4), 3'd1, 4'h2, (i == 2), 4'h5);
      settle();
      if (outBusy[0]) busyCnt++;
      if (outDone[0]) begin
        doneCnt++;
        check("clrDone follows busy", busyCnt, 8);
      end
      if (outErr[0]) errCnt++;
      checkModel();
      advance();
    end
    check("sweep busy cycles", busyCnt, 8);
    check("sweep clrDone pulses", doneCnt, 1);
    check("sweep wrErr pulses", errCnt, 1);
    for (int a = 0; a < NREG; a++) begin
      drive(3'(a), 3'(a), 1'b0, 3'd0, 4'd0, 1'b0, 4'd0);
      settle();
      check($sformatf("swept addr%0d", a), int'(outA[0]), 9);
      checkModel();
      advance();
    end

    // Zero register: dropped write, sweep skips address 0.
    drive(3'd0, 3'd0, 1'b1, 3'd0, 4'h5, 1'b0, 4'd0);
    settle();
    check("zero reg write bypass", int'(outA[3]), 0);
    check("zero reg wrErr", int'(outErr[3]), 0);
    checkModel();
    advance();
    drive(3'd0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b1, 4'hC);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(3'd0, 3'd7, 1'b0, 3'd0, 4'd0, 1'b0, 4'd0);
      tick();
    end
    for (int a = 0; a < NREG; a++) begin
      drive(3'(a), 3'(a), 1'b0, 3'd0, 4'd0, 1'b0, 4'd0);
      settle();
      check($sformatf("zero cfg addr%0d", a), int'(outA[3]), (a == 0) ? 0 : 12);
      checkModel();
      advance();
    end

    // Reset in sweep cycle 3: async clear, no clrDone afterwards.
    drive(3'd5, 3'd6, 1'b0, 3'd0, 4'd0, 1'b1, 4'hC);
    tick();
    drive(3'd5, 3'd6, 1'b0, 3'd0, 4'd0, 1'b0, 4'd0);
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    check("mid-sweep reset busy", int'(outBusy[3]), 0);
    check("mid-sweep reset read", int'(outA[3]), 0);
    checkModel();
    @(negedge clk);
    rst = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive(3'(i), 3'(i + 3), 1'b0, 3'd0, 4'd0, 1'b0, 4'd0);
      settle();
      if (outDone[3]) doneCnt++;
      checkModel();
      advance();
    end
    check("no clrDone after reset abort", doneCnt, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)),
            3'($urandom_range(7)), 4'($urandom_range(15)),
            ($urandom_range(15) == 0), 4'($urandom_range(15)));
      tick();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
